// File: rtl/tinyalu_mem_responder.sv
// -----------------------------------------------------------------------------
// tinyalu_mem_responder
//   Single-port 16-bit data memory that answers the processor's load/store
//   handshake after a fixed, programmable latency. It services one request at
//   a time. After answering, it waits for the request to be released before it
//   returns to idle, so a held request is never serviced twice.
//
// Parameters
//   DEPTH    number of 16-bit words (addresses 0..DEPTH-1, DEPTH <= 16384)
//   LATENCY  cycles from the accepting edge to mem_resp (1..8)
//
// Ports
//   clk          system clock, rising edge
//   reset_n      asynchronous active-low reset
//   cs           chip select; requests are considered only while high
//   read_req     load request (level)
//   write_req    store request (level)
//   addrout      14-bit word address
//   datatomem    16-bit store data
//   datafrommem  registered load data; holds until the next read completes
//   mem_resp     one-cycle completion pulse for loads and stores
//
// Build option
//   TINYALU_MEM_CLEAR_EN  when defined, zero the whole array after every
//                         reset (one word per cycle) before accepting requests
// -----------------------------------------------------------------------------
module tinyalu_mem_responder #(
  parameter int DEPTH   = 1024,
  parameter int LATENCY = 6
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        cs,
  input  logic        read_req,
  input  logic        write_req,
  input  logic [13:0] addrout,
  input  logic [15:0] datatomem,
  output logic [15:0] datafrommem,
  output logic        mem_resp
);

  localparam int         AW     = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [3:0] LAT_M1 = 4'(LATENCY - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_BUSY,
    S_RESP,
    S_HOLD
`ifdef TINYALU_MEM_CLEAR_EN
    , S_CLEAR
`endif
  } state_t;

  state_t      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [13:0] addr_q, addr_d;
  logic [15:0] wdata_q, wdata_d;
  logic        is_write_q, is_write_d;
  logic [15:0] rdata_q;
  logic        resp_q;

  logic        valid_req;
  logic        commit;
  logic        addr_ok;
  logic        mem_we;
  logic [AW-1:0] mem_waddr;
  logic [15:0]   mem_wdata;

  logic [15:0] mem [DEPTH];

`ifdef TINYALU_MEM_CLEAR_EN
  // One bit wider than the address so the final index never wraps.
  logic [AW:0] clr_idx_q, clr_idx_d;
`endif

  assign valid_req = cs && (read_req ^ write_req);

  // NOTE: every signal driven here gets a default first, so no path can
  // leave one unassigned and infer a latch.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    is_write_d = is_write_q;
`ifdef TINYALU_MEM_CLEAR_EN
    clr_idx_d  = clr_idx_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (valid_req) begin
          addr_d     = addrout;
          wdata_d    = datatomem;
          is_write_d = write_req;
          if (LATENCY == 1) begin
            state_d = S_RESP;
            cnt_d   = 4'd0;
          end else begin
            state_d = S_BUSY;
            cnt_d   = LAT_M1;
          end
        end
      end
      S_BUSY: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q <= 4'd1) state_d = S_RESP;
      end
      S_RESP: state_d = S_HOLD;
      S_HOLD: begin
        if (!cs || (!read_req && !write_req)) state_d = S_IDLE;
      end
`ifdef TINYALU_MEM_CLEAR_EN
      S_CLEAR: begin
        clr_idx_d = clr_idx_q + 1'b1;
        if (clr_idx_q == (AW + 1)'(DEPTH - 1)) state_d = S_IDLE;
      end
`endif
      default: state_d = S_IDLE;
    endcase
  end

  // The access happens on the edge entering RESP. With LATENCY=1 that is the
  // accepting edge itself, so the *_d copies (fresh inputs in IDLE, latched
  // values in BUSY) select the operation.
  assign commit  = (state_d == S_RESP);
  assign addr_ok = (32'(addr_d) < DEPTH);

  // Write port is gated by reset_n so an edge seen while reset is held low
  // can never commit a store.
  always_comb begin
    mem_we    = 1'b0;
    mem_waddr = addr_d[AW-1:0];
    mem_wdata = wdata_d;
    if (commit && is_write_d && addr_ok) mem_we = reset_n;
`ifdef TINYALU_MEM_CLEAR_EN
    if (state_q == S_CLEAR) begin
      mem_we    = reset_n;
      mem_waddr = clr_idx_q[AW-1:0];
      mem_wdata = 16'h0000;
    end
`endif
  end

  // NOTE: the storage array has no reset; contents survive reset_n and a
  // reset on a RAM would prevent mapping it to a memory macro.
  always_ff @(posedge clk) begin
    if (mem_we) mem[mem_waddr] <= mem_wdata;
  end

  // NOTE: all state is updated with non-blocking assignments so every flop
  // samples values from before the edge.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
`ifdef TINYALU_MEM_CLEAR_EN
      state_q   <= S_CLEAR;
      clr_idx_q <= '0;
`else
      state_q   <= S_IDLE;
`endif
      cnt_q      <= 4'd0;
      addr_q     <= 14'd0;
      wdata_q    <= 16'h0000;
      is_write_q <= 1'b0;
      rdata_q    <= 16'h0000;
      resp_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      is_write_q <= is_write_d;
      resp_q     <= commit;
`ifdef TINYALU_MEM_CLEAR_EN
      clr_idx_q  <= clr_idx_d;
`endif
      if (commit && !is_write_d) begin
        rdata_q <= addr_ok ? mem[addr_d[AW-1:0]] : 16'h0000;
      end
    end
  end

  assign datafrommem = rdata_q;
  assign mem_resp    = resp_q;

endmodule

// File: tb/tb_tinyalu_mem_responder.sv
// -----------------------------------------------------------------------------
// tb_tinyalu_mem_responder
//   Directed bench for tinyalu_mem_responder. Two instances share the clock,
//   reset and request buses: "dut" uses the default LATENCY=6, and "dut_l1"
//   uses LATENCY=1 with its own chip select. Cycle n after an acceptance is
//   sampled 1 time unit after the (n-1)-th rising edge that follows the
//   accepting edge, so mem_resp must first appear at n == LATENCY.
// -----------------------------------------------------------------------------
module tb_tinyalu_mem_responder;

  localparam int DEPTH = 1024;
  localparam int LAT   = 6;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        cs, cs1;
  logic        read_req, write_req;
  logic [13:0] addrout;
  logic [15:0] datatomem;
  logic [15:0] datafrommem, dfm1;
  logic        mem_resp, resp1;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  tinyalu_mem_responder #(.DEPTH(DEPTH), .LATENCY(LAT)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .cs         (cs),
    .read_req   (read_req),
    .write_req  (write_req),
    .addrout    (addrout),
    .datatomem  (datatomem),
    .datafrommem(datafrommem),
    .mem_resp   (mem_resp)
  );

  tinyalu_mem_responder #(.DEPTH(DEPTH), .LATENCY(1)) dut_l1 (
    .clk        (clk),
    .reset_n    (reset_n),
    .cs         (cs1),
    .read_req   (read_req),
    .write_req  (write_req),
    .addrout    (addrout),
    .datatomem  (datatomem),
    .datafrommem(dfm1),
    .mem_resp   (resp1)
  );

  // Watchdog: every loop below is bounded, this only guards against a stall.
  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic idle_inputs();
    cs        = 1'b0;
    cs1       = 1'b0;
    read_req  = 1'b0;
    write_req = 1'b0;
    addrout   = 14'd0;
    datatomem = 16'h0000;
  endtask

  task automatic do_reset();
    @(negedge clk);
    idle_inputs();
    reset_n = 1'b0;
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
`ifdef TINYALU_MEM_CLEAR_EN
    repeat (DEPTH + 4) @(negedge clk);
`endif
  endtask

  // One transaction: request held from the negedge before the accepting edge
  // until mem_resp is seen, then released. Records first response cycle, the
  // number of high mem_resp samples, and the load data at the response.
  task automatic do_txn(input bit wr, input logic [13:0] a, input logic [15:0] d,
                        input bit on_l1, output int resp_cyc, output int pulses,
                        output logic [15:0] rdata);
    logic r;
    resp_cyc = -1;
    pulses   = 0;
    rdata    = 'x;
    @(negedge clk);
    addrout   = a;
    datatomem = d;
    read_req  = !wr;
    write_req = wr;
    if (on_l1) cs1 = 1'b1;
    else       cs  = 1'b1;
    @(posedge clk);
    for (int n = 1; n <= 16; n++) begin
      #1;
      r = on_l1 ? resp1 : mem_resp;
      if (r) begin
        pulses++;
        if (resp_cyc < 0) begin
          resp_cyc = n;
          rdata    = on_l1 ? dfm1 : datafrommem;
        end
      end
      @(negedge clk);
      if (resp_cyc >= 0) idle_inputs();
      @(posedge clk);
    end
  endtask

  // Counts mem_resp samples of the default instance over n cycles.
  task automatic count_resp(input int n, output int cnt);
    cnt = 0;
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
      if (mem_resp) cnt++;
    end
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    idle_inputs();
    #12;
    checks++;
    if (mem_resp !== 1'b0) begin
      failures++;
      $display("FAIL reset_mem_resp: got %b expected 0", mem_resp);
    end
    checks++;
    if (datafrommem !== 16'h0000) begin
      failures++;
      $display("FAIL reset_datafrommem: got %h expected 0000", datafrommem);
    end
    checks++;
    if (resp1 !== 1'b0 || dfm1 !== 16'h0000) begin
      failures++;
      $display("FAIL reset_l1: got resp=%b data=%h expected resp=0 data=0000", resp1, dfm1);
    end
    do_reset();
  endtask

  task automatic test_store_load();
    int rc, np;
    logic [15:0] rd;
    do_txn(1'b1, 14'h0010, 16'hA5C3, 1'b0, rc, np, rd);
    checks++;
    if (rc !== LAT || np !== 1) begin
      failures++;
      $display("FAIL store_timing: got cycle=%0d pulses=%0d expected cycle=6 pulses=1", rc, np);
    end
    do_txn(1'b0, 14'h0010, 16'h0000, 1'b0, rc, np, rd);
    checks++;
    if (rc !== LAT || np !== 1) begin
      failures++;
      $display("FAIL load_timing: got cycle=%0d pulses=%0d expected cycle=6 pulses=1", rc, np);
    end
    checks++;
    if (rd !== 16'hA5C3) begin
      failures++;
      $display("FAIL load_data: got %h expected a5c3", rd);
    end
    // A later store must not disturb the last load data.
    do_txn(1'b1, 14'h0011, 16'h5A5A, 1'b0, rc, np, rd);
    checks++;
    if (datafrommem !== 16'hA5C3) begin
      failures++;
      $display("FAIL load_data_hold: got %h expected a5c3", datafrommem);
    end
  endtask

  task automatic test_out_of_range();
    int rc, np;
    logic [15:0] rd;
    do_txn(1'b1, 14'h0000, 16'h0042, 1'b0, rc, np, rd);
    do_txn(1'b1, 14'h0400, 16'h1234, 1'b0, rc, np, rd);
    checks++;
    if (rc !== LAT || np !== 1) begin
      failures++;
      $display("FAIL oor_write_timing: got cycle=%0d pulses=%0d expected cycle=6 pulses=1", rc, np);
    end
    do_txn(1'b0, 14'h0400, 16'h0000, 1'b0, rc, np, rd);
    checks++;
    if (rc !== LAT || rd !== 16'h0000) begin
      failures++;
      $display("FAIL oor_read: got cycle=%0d data=%h expected cycle=6 data=0000", rc, rd);
    end
    // The dropped write must not alias onto address 0.
    do_txn(1'b0, 14'h0000, 16'h0000, 1'b0, rc, np, rd);
    checks++;
    if (rd !== 16'h0042) begin
      failures++;
      $display("FAIL oor_no_alias: got %h expected 0042", rd);
    end
  endtask

  task automatic test_illegal_and_held();
    int cnt;
    @(negedge clk);
    cs = 1'b1; read_req = 1'b1; write_req = 1'b1; addrout = 14'h0010;
    count_resp(20, cnt);
    checks++;
    if (cnt !== 0) begin
      failures++;
      $display("FAIL both_req: got %0d pulses expected 0", cnt);
    end
    @(negedge clk);
    read_req = 1'b0; write_req = 1'b0;
    count_resp(10, cnt);
    checks++;
    if (cnt !== 0) begin
      failures++;
      $display("FAIL no_req: got %0d pulses expected 0", cnt);
    end
    @(negedge clk);
    cs = 1'b0; read_req = 1'b1;
    count_resp(10, cnt);
    checks++;
    if (cnt !== 0) begin
      failures++;
      $display("FAIL cs_low: got %0d pulses expected 0", cnt);
    end
    @(negedge clk);
    cs = 1'b1;
    count_resp(20, cnt);
    checks++;
    if (cnt !== 1) begin
      failures++;
      $display("FAIL held_read: got %0d pulses expected 1", cnt);
    end
    checks++;
    if (datafrommem !== 16'hA5C3) begin
      failures++;
      $display("FAIL held_read_data: got %h expected a5c3", datafrommem);
    end
    @(negedge clk);
    idle_inputs();
    repeat (2) @(negedge clk);
  endtask

  task automatic test_reset_mid_write();
    int rc, np, cnt;
    logic [15:0] rd, exp_prior;
    do_txn(1'b1, 14'd5, 16'h0BEE, 1'b0, rc, np, rd);
    @(negedge clk);
    cs = 1'b1; write_req = 1'b1; addrout = 14'd5; datatomem = 16'hFFFF;
    @(posedge clk);
    cnt = 0;
    for (int n = 1; n <= 3; n++) begin
      #1;
      if (mem_resp) cnt++;
      if (n < 3) @(posedge clk);
    end
    reset_n = 1'b0;
    idle_inputs();
    for (int n = 0; n < 2; n++) begin
      @(posedge clk);
      #1;
      if (mem_resp) cnt++;
    end
    @(negedge clk);
    reset_n = 1'b1;
`ifdef TINYALU_MEM_CLEAR_EN
    repeat (DEPTH + 4) @(negedge clk);
    exp_prior = 16'h0000;
`else
    exp_prior = 16'h0BEE;
`endif
    count_resp(10, np);
    cnt += np;
    checks++;
    if (cnt !== 0) begin
      failures++;
      $display("FAIL reset_abort_resp: got %0d pulses expected 0", cnt);
    end
    checks++;
    if (datafrommem !== 16'h0000) begin
      failures++;
      $display("FAIL reset_abort_data: got %h expected 0000", datafrommem);
    end
    do_txn(1'b0, 14'd5, 16'h0000, 1'b0, rc, np, rd);
    checks++;
    if (rd !== exp_prior) begin
      failures++;
      $display("FAIL reset_no_commit: got %h expected %h", rd, exp_prior);
    end
  endtask

  task automatic test_latency1();
    int rc, np;
    logic [15:0] rd;
    do_txn(1'b1, 14'd0, 16'h7E57, 1'b1, rc, np, rd);
    checks++;
    if (rc !== 1 || np !== 1) begin
      failures++;
      $display("FAIL l1_write: got cycle=%0d pulses=%0d expected cycle=1 pulses=1", rc, np);
    end
    do_txn(1'b0, 14'd0, 16'h0000, 1'b1, rc, np, rd);
    checks++;
    if (rc !== 1 || rd !== 16'h7E57) begin
      failures++;
      $display("FAIL l1_read: got cycle=%0d data=%h expected cycle=1 data=7e57", rc, rd);
    end
  endtask

  // Two loads issued one after another, each released after its response.
  task automatic test_back_to_back();
    int rc, np;
    logic [15:0] rd;
    do_txn(1'b0, 14'h0011, 16'h0000, 1'b0, rc, np, rd);
    checks++;
    if (rc !== LAT || rd !== 16'h5A5A) begin
      failures++;
      $display("FAIL b2b_first: got cycle=%0d data=%h expected cycle=6 data=5a5a", rc, rd);
    end
    do_txn(1'b0, 14'h0010, 16'h0000, 1'b0, rc, np, rd);
    checks++;
    if (rc !== LAT || rd !== 16'hA5C3) begin
      failures++;
      $display("FAIL b2b_second: got cycle=%0d data=%h expected cycle=6 data=a5c3", rc, rd);
    end
  endtask

`ifdef TINYALU_MEM_CLEAR_EN
  task automatic test_clear();
    int rc, np, cnt;
    logic [15:0] rd;
    do_txn(1'b1, 14'd1023, 16'h5555, 1'b0, rc, np, rd);
    @(negedge clk);
    idle_inputs();
    reset_n = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    repeat (10) @(negedge clk);
    cs = 1'b1; read_req = 1'b1; addrout = 14'd1023;
    count_resp(3, cnt);
    @(negedge clk);
    idle_inputs();
    count_resp(20, np);
    cnt += np;
    checks++;
    if (cnt !== 0) begin
      failures++;
      $display("FAIL clear_ignores_req: got %0d pulses expected 0", cnt);
    end
    repeat (DEPTH) @(negedge clk);
    do_txn(1'b0, 14'd1023, 16'h0000, 1'b0, rc, np, rd);
    checks++;
    if (rc !== LAT || rd !== 16'h0000) begin
      failures++;
      $display("FAIL clear_result: got cycle=%0d data=%h expected cycle=6 data=0000", rc, rd);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_store_load();
    test_out_of_range();
    test_illegal_and_held();
    test_back_to_back();
    test_reset_mid_write();
    test_latency1();
`ifdef TINYALU_MEM_CLEAR_EN
    test_clear();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
